// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_scoreboard: shift-register scoreboard that stalls decode on RAW    |
// | hazards. Optional stall counter under HAZARD_STATS_EN.  Rev 1.0           |
// +--------------------------------------------------------------------------+
module hazard_scoreboard #(
  parameter int PIPE_DEPTH = 3,
  parameter int WB_BYPASS  = 0,
  parameter int REG_BITS   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode_step_2,
  input  logic [REG_BITS-1:0] rs_step_2,
  input  logic [REG_BITS-1:0] rt_step_2,
  input  logic [REG_BITS-1:0] rd_step_2,
  input  logic                valid_step_2,
  input  logic                flush,
`ifdef HAZARD_STATS_EN
  input  logic                stats_clr,
  output logic [15:0]         stall_count,
`endif
  output logic                is_hazzard,
  output logic                bubble_step_3,
  output logic [REG_BITS-1:0] wnum_step_5,
  output logic                wvalid_step_5
);

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;

  // With bypass, the writeback slot's result reaches decode in the same cycle.
  localparam int CMP_SLOTS = (WB_BYPASS != 0) ? PIPE_DEPTH - 1 : PIPE_DEPTH;

  logic                                 dec_writes;
  logic                                 dec_use_rs;
  logic                                 dec_use_rt;
  logic [REG_BITS-1:0]                  dec_dest;
  logic                                 src_match;
  logic                                 accept;
  logic                                 load_valid;

  logic [PIPE_DEPTH-1:0]                slot_valid_q, slot_valid_d;
  logic [PIPE_DEPTH-1:0][REG_BITS-1:0]  slot_dest_q, slot_dest_d;
  logic                                 bubble_q, bubble_d;

  always_comb begin
    dec_writes = 1'b0;
    dec_use_rs = 1'b0;
    dec_use_rt = 1'b0;
    dec_dest   = '0;
    case (opcode_step_2)
      c_op_rtype: begin
        dec_writes = 1'b1;
        dec_dest   = rd_step_2;
        dec_use_rs = 1'b1;
        dec_use_rt = 1'b1;
      end
      c_op_addi, c_op_lw: begin
        dec_writes = 1'b1;
        dec_dest   = rt_step_2;
        dec_use_rs = 1'b1;
      end
      c_op_sw, c_op_beq: begin
        dec_use_rs = 1'b1;
        dec_use_rt = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    src_match = 1'b0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      if (i < CMP_SLOTS && slot_valid_q[i]) begin
        if (dec_use_rs && (rs_step_2 != '0) && (slot_dest_q[i] == rs_step_2))
          src_match = 1'b1;
        if (dec_use_rt && (rt_step_2 != '0) && (slot_dest_q[i] == rt_step_2))
          src_match = 1'b1;
      end
    end
  end

  // Flush outranks the hazard: a killed instruction never stalls.
  always_comb begin
    is_hazzard  = valid_step_2 & ~flush & src_match;
    accept      = valid_step_2 & ~flush & ~src_match;
    load_valid  = accept & dec_writes & (dec_dest != '0);
    slot_valid_d = {slot_valid_q[PIPE_DEPTH-2:0], load_valid};
    slot_dest_d  = {slot_dest_q[PIPE_DEPTH-2:0], (load_valid ? dec_dest : {REG_BITS{1'b0}})};
    bubble_d     = ~accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid_q <= '0;
      slot_dest_q  <= '0;
      bubble_q     <= 1'b1;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_dest_q  <= slot_dest_d;
      bubble_q     <= bubble_d;
    end
  end

  assign bubble_step_3 = bubble_q;
  assign wvalid_step_5 = slot_valid_q[PIPE_DEPTH-1];
  assign wnum_step_5   = slot_valid_q[PIPE_DEPTH-1] ? slot_dest_q[PIPE_DEPTH-1] : '0;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stats_clr)
      stall_count_d = 16'h0000;
    else if (is_hazzard && (stall_count_q != 16'hFFFF))
      stall_count_d = stall_count_q + 16'h0001;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_count_q <= 16'h0000;
    else     stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hazard_scoreboard: two scoreboards (no bypass / bypass) checked        |
// | against a slot-array model; HAZARD_STATS_EN adds counter checks. Rev 1.0  |
// +--------------------------------------------------------------------------+
module tb_hazard_scoreboard;

  localparam int P = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [4:0] rs, rt, rd;
  logic       valid, flush;

  logic       hz  [2];
  logic       bub [2];
  logic       wv  [2];
  logic [4:0] wn  [2];
`ifdef HAZARD_STATS_EN
  logic        stats_clr;
  logic [15:0] sc [2];
  logic [15:0] mc [2];
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.PIPE_DEPTH(P), .WB_BYPASS(0), .REG_BITS(5)) u_dut0 (
    .clk(clk), .rst(rst), .opcode_step_2(op), .rs_step_2(rs), .rt_step_2(rt),
    .rd_step_2(rd), .valid_step_2(valid), .flush(flush),
`ifdef HAZARD_STATS_EN
    .stats_clr(stats_clr), .stall_count(sc[0]),
`endif
    .is_hazzard(hz[0]), .bubble_step_3(bub[0]), .wnum_step_5(wn[0]), .wvalid_step_5(wv[0])
  );

  hazard_scoreboard #(.PIPE_DEPTH(P), .WB_BYPASS(1), .REG_BITS(5)) u_dut1 (
    .clk(clk), .rst(rst), .opcode_step_2(op), .rs_step_2(rs), .rt_step_2(rt),
    .rd_step_2(rd), .valid_step_2(valid), .flush(flush),
`ifdef HAZARD_STATS_EN
    .stats_clr(stats_clr), .stall_count(sc[1]),
`endif
    .is_hazzard(hz[1]), .bubble_step_3(bub[1]), .wnum_step_5(wn[1]), .wvalid_step_5(wv[1])
  );

  // Reference model: one array of in-flight writes per instance.
  logic       mv [2][P];
  logic [4:0] md [2][P];
  logic       mb [2];

  function automatic logic reads_rs(input logic [5:0] o);
    return (o == 6'd0) || (o == 6'd8) || (o == 6'd35) || (o == 6'd43) || (o == 6'd4);
  endfunction

  function automatic logic reads_rt(input logic [5:0] o);
    return (o == 6'd0) || (o == 6'd43) || (o == 6'd4);
  endfunction

  function automatic logic [4:0] write_dest(input logic [5:0] o, input logic [4:0] t,
                                            input logic [4:0] d);
    if (o == 6'd0) return d;
    if (o == 6'd8 || o == 6'd35) return t;
    return 5'd0;
  endfunction

  function automatic logic model_hz(input int k);
    int   lim;
    logic m;
    lim = (k == 1) ? P - 1 : P;
    m = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (mv[k][i] && reads_rs(op) && rs != 0 && md[k][i] == rs) m = 1'b1;
      if (mv[k][i] && reads_rt(op) && rt != 0 && md[k][i] == rt) m = 1'b1;
    end
    return valid && !flush && m;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < P; i++) begin mv[k][i] = 1'b0; md[k][i] = 5'd0; end
        mb[k] = 1'b1;
`ifdef HAZARD_STATS_EN
        mc[k] = 16'd0;
`endif
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic       h, acc;
        logic [4:0] d;
        h   = model_hz(k);
        acc = valid && !flush && !h;
        d   = write_dest(op, rt, rd);
`ifdef HAZARD_STATS_EN
        if (stats_clr) mc[k] = 16'd0;
        else if (h && mc[k] != 16'hFFFF) mc[k] = mc[k] + 16'd1;
`endif
        for (int i = P - 1; i > 0; i--) begin mv[k][i] = mv[k][i-1]; md[k][i] = md[k][i-1]; end
        mv[k][0] = acc && (d != 5'd0);
        md[k][0] = (acc && d != 5'd0) ? d : 5'd0;
        mb[k]    = !acc;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("hz%0d", k),  16'(hz[k]),  16'(model_hz(k)));
      check($sformatf("bub%0d", k), 16'(bub[k]), 16'(mb[k]));
      check($sformatf("wv%0d", k),  16'(wv[k]),  16'(mv[k][P-1]));
      check($sformatf("wn%0d", k),  16'(wn[k]),  16'(md[k][P-1]));
`ifdef HAZARD_STATS_EN
      check($sformatf("cnt%0d", k), sc[k], mc[k]);
`endif
    end
  end

  task automatic drive(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic v, input logic f);
    op = o; rs = s; rt = t; rd = d; valid = v; flush = f;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int         n0, n1, b0, b1;
  logic       seen1;
  logic [4:0] wn0_last, wn1_free;
  logic       wv0_last, wv1_free;

  initial begin
    rst = 1'b1;
`ifdef HAZARD_STATS_EN
    stats_clr = 1'b0;
`endif
    drive(6'd63, 0, 0, 0, 0, 0);
    step(2);
    check("rst_hz",  16'(hz[0]),  16'd0);
    check("rst_bub", 16'(bub[0]), 16'd1);
    check("rst_wv",  16'(wv[0]),  16'd0);
    check("rst_wn",  16'(wn[0]),  16'd0);
    @(negedge clk); rst = 1'b0;
    step(1);

    // add $3,$1,$2 ; sub $5,$3,$4 back-to-back
    drive(6'd0, 5'd1, 5'd2, 5'd3, 1, 0);
    step(1);
    drive(6'd0, 5'd3, 5'd4, 5'd5, 1, 0);
    n0 = 0; n1 = 0; b0 = 0; b1 = 0; seen1 = 1'b0;
    wn0_last = '0; wv0_last = 1'b0; wn1_free = '0; wv1_free = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (hz[0]) begin n0++; wn0_last = wn[0]; wv0_last = wv[0]; end
      if (hz[1]) n1++;
      if (bub[0]) b0++;
      if (bub[1]) b1++;
      if (!hz[1] && n1 > 0 && !seen1) begin seen1 = 1'b1; wn1_free = wn[1]; wv1_free = wv[1]; end
      if (!hz[0]) break;
      @(posedge clk); #1;
    end
    check("stall_len_nobyp", 16'(n0), 16'd3);
    check("stall_len_byp",   16'(n1), 16'd2);
    check("bubbles_nobyp",   16'(b0), 16'd3);
    check("bubbles_byp",     16'(b1), 16'd2);
    check("wb_num_nobyp",    16'(wn0_last), 16'd3);
    check("wb_vld_nobyp",    16'(wv0_last), 16'd1);
    check("wb_num_byp",      16'(wn1_free), 16'd3);
    check("wb_vld_byp",      16'(wv1_free), 16'd1);
    step(1);
    drive(6'd63, 0, 0, 0, 0, 0);
    step(4);
`ifdef HAZARD_STATS_EN
    check("cnt_after_stall0", sc[0], 16'd3);
    check("cnt_after_stall1", sc[1], 16'd2);
    stats_clr = 1'b1; step(1); stats_clr = 1'b0;
    check("cnt_cleared", sc[0], 16'd0);
`endif

    // addi $0,$1,5 then add $2,$0,$0
    drive(6'd8, 5'd1, 5'd0, 5'd0, 1, 0);
    @(negedge clk); check("addi0_hz", 16'(hz[0]), 16'd0);
    step(1);
    drive(6'd0, 5'd0, 5'd0, 5'd2, 1, 0);
    @(negedge clk); check("add_r0_hz", 16'(hz[0]), 16'd0);
    step(1);
    drive(6'd63, 0, 0, 0, 0, 0);
    step(1);
    check("addi0_slot_vld", 16'(wv[0]), 16'd0);
    step(1);
    check("add2_wv", 16'(wv[0]), 16'd1);
    check("add2_wn", 16'(wn[0]), 16'd2);
    step(2);

    // lw $4,0($1) then beq $4,$4 flushed
    drive(6'd35, 5'd1, 5'd4, 5'd0, 1, 0);
    step(1);
    drive(6'd4, 5'd4, 5'd4, 5'd0, 1, 1);
    @(negedge clk);
    check("flush_hz0", 16'(hz[0]), 16'd0);
    check("flush_hz1", 16'(hz[1]), 16'd0);
    step(1);
    check("flush_bub", 16'(bub[0]), 16'd1);
    drive(6'd63, 0, 0, 0, 0, 0);
    step(3);

    // sw $7,0($8) then add $9,$7,$8
    drive(6'd43, 5'd8, 5'd7, 5'd0, 1, 0);
    step(1);
    drive(6'd0, 5'd7, 5'd8, 5'd9, 1, 0);
    @(negedge clk); check("sw_nodep_hz", 16'(hz[0]), 16'd0);
    step(1);
    drive(6'd63, 0, 0, 0, 0, 0);
    step(4);

    // async reset in the middle of a stall
    drive(6'd0, 5'd1, 5'd2, 5'd3, 1, 0);
    step(1);
    drive(6'd0, 5'd3, 5'd4, 5'd5, 1, 0);
    @(negedge clk);
    check("pre_rst_hz", 16'(hz[0]), 16'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_hz0", 16'(hz[0]), 16'd0);
    check("midrst_hz1", 16'(hz[1]), 16'd0);
    check("midrst_bub", 16'(bub[0]), 16'd1);
    drive(6'd63, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    step(4);
    check("post_rst_wv", 16'(wv[0]), 16'd0);

    // randomized traffic with a small register range to provoke hazards
    for (int c = 0; c < 3000; c++) begin
      logic [5:0] o;
      case ($urandom_range(0, 5))
        0: o = 6'd0;
        1: o = 6'd8;
        2: o = 6'd35;
        3: o = 6'd43;
        4: o = 6'd4;
        default: o = 6'($urandom_range(0, 63));
      endcase
      drive(o, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
`ifdef HAZARD_STATS_EN
      stats_clr = ($urandom_range(0, 31) == 0);
`endif
      step(1);
    end
    drive(6'd63, 0, 0, 0, 0, 0);
    step(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Produces the `is_hazzard` stall signal that the step-2 (decode) control FSM consumes.
- Tracks destination registers of instructions in flight between step 3 and step 5 (writeback) in a shift-register scoreboard.
- Stalls decode while a step-2 source register is still pending a write.
- On stall or flush, injects a bubble into step 3 and reports bubble status downstream.

Parameters:
- PIPE_DEPTH, 3: number of scoreboard slots, one per stage from step 3 to step 5 inclusive; legal 2..6.
- WB_BYPASS, 0: 1 = register file write in the last slot is visible to a same-cycle step-2 read, so the last slot is excluded from the compare.
- REG_BITS, 5: register-number width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- opcode_step_2  input  6  opcode of the instruction in decode.
- rs_step_2  input  REG_BITS  rs field in decode.
- rt_step_2  input  REG_BITS  rt field in decode.
- rd_step_2  input  REG_BITS  rd field in decode.
- valid_step_2  input  1  decode slot holds a real instruction.
- flush  input  1  branch taken; kill the decode instruction this cycle.
- is_hazzard  output  1  stall fetch/decode this cycle (combinational from scoreboard and decode fields).
- bubble_step_3  output  1  registered; step 3 holds an injected bubble.
- wnum_step_5  output  REG_BITS  destination register in the last slot, or 0 if that slot is invalid.
- wvalid_step_5  output  1  last slot holds a valid register write.

Behaviour:
- Opcode decode:
  - 000000 (add/sub): writes rd; reads rs and rt.
  - 001000 (addi): writes rt; reads rs.
  - 100011 (lw): writes rt; reads rs.
  - 101011 (sw): no write; reads rs and rt.
  - 000100 (beq): no write; reads rs and rt.
  - Any other opcode: no reads, no writes (treated as NOP).
- Scoreboard:
  - PIPE_DEPTH slots, each {valid, dest[REG_BITS-1:0]}.
  - Slot 0 = step 3; slot PIPE_DEPTH-1 = step 5.
  - A write to register 0 never produces a valid entry; the slot is stored as valid=0.
- Hazard compare:
  - `is_hazzard` = valid_step_2 & !flush & (some used source != 0 matches the dest of some valid slot).
  - The compared slot range is 0..PIPE_DEPTH-1 when WB_BYPASS=0, and 0..PIPE_DEPTH-2 when WB_BYPASS=1.
- Each rising clk, all slots shift: slot[i+1] <= slot[i]. Slot 0 loads:
  - If valid_step_2 & !flush & !is_hazzard: the decode instruction's {writes && dest!=0, dest}; bubble_step_3 <= 0.
  - Otherwise: {0, 0}; bubble_step_3 <= 1.
- Stall duration:
  - A dependent instruction directly behind its producer stalls PIPE_DEPTH cycles with WB_BYPASS=0, and PIPE_DEPTH-1 cycles with WB_BYPASS=1.
  - The stall is released automatically as the producer shifts out; no separate counter.
- Simultaneous events:
  - flush has priority over hazard: `is_hazzard`=0 and a bubble is inserted.
  - Multiple matching slots give one hazard; release occurs when the youngest match leaves the compared range.
- Reset (asynchronous, any time including mid-stall):
  - All slots invalid, dest 0.
  - bubble_step_3=1, wvalid_step_5=0, wnum_step_5=0.
  - `is_hazzard` goes to 0 immediately, since no slot is valid.
- Outputs wnum_step_5 and wvalid_step_5 are taken directly from the last slot, so they are registered.

Optional Feature:
- HAZARD_STATS_EN defined:
  - Adds output `stall_count` [15:0] and input `stats_clr`.
  - `stall_count` increments on each clk edge where `is_hazzard`=1, and saturates at 16'hFFFF.
  - `stats_clr` zeroes the count synchronously and has priority over the increment.
  - Async reset clears the count to 0.
- HAZARD_STATS_EN undefined: neither port exists and there is no counter logic.

Test Plan:
- Reset asserted mid-stall -> `is_hazzard`=0 immediately; after release, slots are empty and wvalid_step_5=0.
- add $3,$1,$2 then sub $5,$3,$4 back-to-back (PIPE_DEPTH=3, WB_BYPASS=0) -> `is_hazzard`=1 for exactly 3 cycles and bubble_step_3=1 for 3 cycles; wnum_step_5=3 with wvalid_step_5=1 on the cycle the stall drops.
- Same sequence with WB_BYPASS=1 -> stall of 2 cycles.
- addi $0,$1,5 then add $2,$0,$0 -> no stall, and slot for addi has valid=0.
- lw $4,0($1) followed by beq $4,$4 with flush=1 on the beq's decode cycle -> `is_hazzard`=0 and a bubble is inserted.
- sw $7,0($8) then add $9,$7,$8 -> no stall, since sw does not write; with HAZARD_STATS_EN, the earlier 3-cycle stall gives stall_count=3, and `stats_clr` then returns it to 0.
